// File: rtl/flag_event_scheduler_if.sv
// Command bus from the two flag requesters (A = pulse engine, B = host).
// The scheduler raises ready on the requester it grants.
interface flag_event_scheduler_if #(
  parameter int CH_W    = 3,
  parameter int DELAY_W = 16
);
  logic               a_valid;
  logic               a_ready;
  logic [CH_W-1:0]    a_chan;
  logic [1:0]         a_op;
  logic [DELAY_W-1:0] a_delay;

  logic               b_valid;
  logic               b_ready;
  logic [CH_W-1:0]    b_chan;
  logic [1:0]         b_op;
  logic [DELAY_W-1:0] b_delay;

  modport master (
    output a_valid, a_chan, a_op, a_delay,
    output b_valid, b_chan, b_op, b_delay,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_chan, a_op, a_delay,
    input  b_valid, b_chan, b_op, b_delay,
    output a_ready, b_ready
  );
endinterface

// File: rtl/flag_event_scheduler.sv
// Round-robin timed set/reset/toggle of a flag bank; a command accepted at edge E0
// with delay d is applied at edge E0+d+2, and both readies stay low until back in IDLE.
module flag_event_scheduler #(
  parameter int                   NUM_FLAGS  = 8,
  parameter int                   CH_W       = 3,
  parameter int                   DELAY_W    = 16,
  parameter logic [NUM_FLAGS-1:0] INIT_FLAGS = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  flag_event_scheduler_if.slave cmd,
  input  logic                 clear_all,
  output logic [NUM_FLAGS-1:0] flags,
  output logic                 busy,
  output logic                 done,
  output logic                 last_grant,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, WAIT, APPLY} state_t;

  state_t             state, state_nxt;
  logic               prio_b;
  logic               grant_a, grant_b;
  logic [CH_W-1:0]    chan_q;
  logic [1:0]         op_q;
  logic [DELAY_W-1:0] cnt;
  logic               chan_ok;

  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && !clear_all) begin
          if (cmd.a_valid && (!cmd.b_valid || !prio_b)) grant_a = 1'b1;
          else if (cmd.b_valid)                         grant_b = 1'b1;
        end
        if (grant_a || grant_b) state_nxt = WAIT;
      end
      WAIT:    if (cnt == '0) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear_all) state_nxt = IDLE;
  end

  assign cmd.a_ready = grant_a;
  assign cmd.b_ready = grant_b;
  assign busy        = (state != IDLE);

  // Out-of-range channels may exist when 2^CH_W > NUM_FLAGS.
  always_comb begin
    chan_ok = 1'b0;
    for (int i = 0; i < NUM_FLAGS; i++)
      if (chan_q == CH_W'(i)) chan_ok = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      flags      <= INIT_FLAGS;
      prio_b     <= 1'b0;
      last_grant <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      chan_q     <= '0;
      op_q       <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (clear_all) begin
        flags <= '0;
        err   <= 1'b0;
      end else begin
        if (grant_a || grant_b) begin
          chan_q     <= grant_b ? cmd.b_chan  : cmd.a_chan;
          op_q       <= grant_b ? cmd.b_op    : cmd.a_op;
          cnt        <= grant_b ? cmd.b_delay : cmd.a_delay;
          last_grant <= grant_b;
          prio_b     <= grant_a;
        end else if (state == WAIT && cnt != '0) begin
          cnt <= cnt - 1'b1;
        end

        if (state == APPLY) begin
          done <= 1'b1;
          if (!chan_ok) begin
            err <= 1'b1;
          end else begin
            for (int i = 0; i < NUM_FLAGS; i++) begin
              if (chan_q == CH_W'(i)) begin
                case (op_q)
                  2'b01:   flags[i] <= 1'b1;
                  2'b10:   flags[i] <= 1'b0;
                  2'b11:   flags[i] <= ~flags[i];
                  default: flags[i] <= flags[i];
                endcase
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/flag_event_scheduler.md
# flag_event_scheduler

Timed controller for a bank of set/reset status flags shared between the pulse-program engine (requester A) and the host interface (requester B). Each requester submits set/reset/toggle commands with a per-command delay. A round-robin arbiter admits one command at a time, counts out its delay, and then applies it to the addressed flag. The registered flag bank drives the trigger and status lines consumed by the rest of the FPGA fabric.

## Interface
- NUM_FLAGS, 8, number of flag bits
- CH_W, 3, channel index width; 2^CH_W >= NUM_FLAGS
- DELAY_W, 16, delay counter width
- INIT_FLAGS, {NUM_FLAGS{1'b0}}, flag values after reset

Ports:
- clock  in  1  system clock; all logic is on posedge
- reset  in  1  synchronous, active-high
- a_valid / b_valid  in  1  command present from A / B
- a_ready / b_ready  out  1  command accepted this cycle; handshake completes when valid & ready
- a_chan / b_chan  in  CH_W  target flag index
- a_op / b_op  in  2  01 set, 10 reset, 11 toggle, 00 no-op (delay marker)
- a_delay / b_delay  in  DELAY_W  extra cycles to wait before applying
- clear_all  in  1  synchronous abort; clears all flags to 0
- flags  out  NUM_FLAGS  registered flag bank
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when a command is applied
- last_grant  out  1  requester of the most recently accepted command (0 = A, 1 = B)
- err  out  1  sticky; set when a command addresses chan >= NUM_FLAGS

## Operation
- State machine: IDLE, WAIT, APPLY.
- **IDLE:**
  - If exactly one of a_valid / b_valid is high, that requester is granted.
  - If both are high, the grant goes to the requester holding priority. Priority then passes to the other requester.
  - The ready of the granted requester is high combinationally in the same cycle. The other ready stays low.
  - On the accepting edge, chan, op and delay are captured, last_grant is updated, the counter is loaded with delay, and the state moves to WAIT.
- **WAIT:**
  - If the counter is 0, move to APPLY. Otherwise decrement the counter.
  - Input commands are ignored in this state; both readies are low.
- **APPLY:**
  - At the edge, apply the captured op to flags[chan]: set → 1, reset → 0, toggle → invert, no-op → unchanged.
  - At the same edge, done is registered high for one cycle and the state returns to IDLE.
  - If chan >= NUM_FLAGS, flags are left unchanged, err is set, and done still pulses.
- **Arbiter:**
  - The priority pointer is updated only on an accepted handshake.
  - An uncontested grant also passes priority to the other requester.
- **clear_all:** (dominates all other inputs except reset)
  - At the edge: flags → 0, state → IDLE, err → 0, done → 0.
  - Any pending command is discarded without a done pulse.
  - Both readies are low in any cycle where clear_all is high.
  - last_grant and the priority pointer are retained.
- **reset:** (dominates everything)
  - flags → INIT_FLAGS, state IDLE, priority to A, last_grant 0, err 0, done 0, counter 0.
  - Readies are low while reset is high.

## Timing
- Accept edge E0 has delay d. Flags change and done rises after edge E0+d+2. The state is back in IDLE in that cycle, so the next accept can occur at edge E0+d+3.
- Back-to-back commands with d=0 sustain a throughput of one command per 3 cycles.
- busy is high from the cycle after E0 through the APPLY cycle inclusive.
- d = 2^DELAY_W − 1 must complete without wrap: the counter only decrements while non-zero.
- Flags change only in APPLY, or on clear_all / reset. There are no glitches between updates.
- Output values in reset:
  - flags = INIT_FLAGS
  - busy = 0
  - done = 0
  - last_grant = 0
  - err = 0
  - a_ready = b_ready = 0

## Test plan
- **Reset:** after reset, A sends set chan 3, delay 0, accepted at edge E0 → flags = 0x08 and done = 1 after edge E0+2; busy high for exactly 2 cycles.
- **Contention:** A and B both hold valid (A set ch0, B set ch1, delay 0) → A is granted first, B second; last_grant reads 0 then 1. A further pair of simultaneous requests grants A again.
- **Long delay:** B toggles ch7 with delay 1000 → flags[7] flips exactly 1002 edges after acceptance; b_ready stays low and a second B command waits until IDLE.
- **Bad channel:** NUM_FLAGS = 6, command on chan 6 → flags unchanged, done pulses, err = 1 and stays high; clear_all then gives err = 0 and flags = 0.
- **Abort:** clear_all asserted in the WAIT cycle of a set-ch2 command with delay 10 → flags = 0, state IDLE next cycle, no done pulse, flags[2] never set.
- **Reset mid-operation:** reset during APPLY with INIT_FLAGS = 0x81 → flags = 0x81, done = 0, priority to A.
